// File: rtl/adiabatic_clock_sequencer.sv
// Four-stage adiabatic power-clock sequencer: stages enter EVAL one phase apart,
// each phase lasting ramp_len+1 cycles, and drain stage by stage after a stop.
//
// state | meaning
// IDLE  | no stage active, waiting for start
// RUN   | stages rotating, new stages still being enabled
// DRAIN | stop accepted, stages retire as they leave RECOVER
module adiabatic_clock_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [3:0]  ramp_len,
    output logic [7:0]  stage_phase,
    output logic [15:0] stage_level,
    output logic        running,
    output logic        cycle_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [1:0] PH_WAIT    = 2'd0;
    localparam logic [1:0] PH_EVAL    = 2'd1;
    localparam logic [1:0] PH_HOLD    = 2'd2;
    localparam logic [1:0] PH_RECOVER = 2'd3;

    state_t     state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [1:0] mp_q, mp_d;
    logic [3:0] act_q, act_d;
    logic       stop_pend_q, stop_pend_d;
    logic [3:0] rl_q, rl_d;
    logic       cdone_q, cdone_d;

    logic       boundary;
    logic [3:0] leave;
    logic [3:0] act_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= 4'd0;
            mp_q        <= PH_WAIT;
            act_q       <= 4'd0;
            stop_pend_q <= 1'b0;
            rl_q        <= 4'd0;
            cdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            mp_q        <= mp_d;
            act_q       <= act_d;
            stop_pend_q <= stop_pend_d;
            rl_q        <= rl_d;
            cdone_q     <= cdone_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        mp_d        = mp_q;
        act_d       = act_q;
        stop_pend_d = stop_pend_q;
        rl_d        = rl_q;
        cdone_d     = 1'b0;
        act_nx      = act_q;
        boundary    = (s_q == rl_q);
        leave       = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (act_q[k] && ((mp_q - 2'(k)) == PH_RECOVER)) leave[k] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    rl_d        = ramp_len;
                    s_d         = 4'd0;
                    mp_d        = PH_EVAL;
                    act_d       = 4'b0001;
                    stop_pend_d = 1'b0;
                end
            end
            RUN: begin
                if (stop) stop_pend_d = 1'b1;
                if (boundary) begin
                    s_d     = 4'd0;
                    mp_d    = mp_q + 2'd1;
                    cdone_d = leave[3];
                    if (stop_pend_q && leave[0]) begin
                        // no stage may start on the edge that enters DRAIN
                        act_d   = act_q & 4'b1110;
                        state_d = DRAIN;
                    end else begin
                        act_d = act_q | {act_q[2:0], 1'b0};
                    end
                end else begin
                    s_d = s_q + 4'd1;
                end
            end
            DRAIN: begin
                if (boundary) begin
                    s_d     = 4'd0;
                    mp_d    = mp_q + 2'd1;
                    cdone_d = leave[3];
                    act_nx  = act_q & ~leave;
                    act_d   = act_nx;
                    if (act_nx == 4'd0) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                        mp_d        = PH_WAIT;
                    end
                end else begin
                    s_d = s_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stage_phase = 8'd0;
        stage_level = 16'd0;
        for (int k = 0; k < 4; k++) begin
            if (act_q[k]) begin
                stage_phase[2*k +: 2] = mp_q - 2'(k);
                case (mp_q - 2'(k))
                    PH_EVAL:    stage_level[4*k +: 4] = s_q;
                    PH_HOLD:    stage_level[4*k +: 4] = rl_q;
                    PH_RECOVER: stage_level[4*k +: 4] = rl_q - s_q;
                    default:    stage_level[4*k +: 4] = 4'd0;
                endcase
            end
        end
    end

    assign running    = (state_q != IDLE);
    assign cycle_done = cdone_q;

endmodule

// File: tb/tb_adiabatic_clock_sequencer.sv
// Scoreboard bench for adiabatic_clock_sequencer: stimulus queues hand-computed
// expectations stamped with a cycle number; a negedge monitor compares them.
module tb_adiabatic_clock_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [3:0]  ramp_len;
    logic [7:0]  stage_phase;
    logic [15:0] stage_level;
    logic        running;
    logic        cycle_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    typedef struct {
        int          at;
        logic [7:0]  ph;
        logic [15:0] lv;
        logic        run;
        logic        cd;
        string       name;
    } exp_t;

    exp_t q[$];

    adiabatic_clock_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .ramp_len    (ramp_len),
        .stage_phase (stage_phase),
        .stage_level (stage_level),
        .running     (running),
        .cycle_done  (cycle_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: cycle c of a run is sampled at the negedge where cyc == t0 + c - 1
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle stamp %0d never sampled", q[0].name, q[0].at);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].at == cyc) begin
            checks++;
            if (stage_phase !== q[0].ph || stage_level !== q[0].lv ||
                running !== q[0].run || cycle_done !== q[0].cd) begin
                errors++;
                $display("FAIL %s: got phase=%h level=%h running=%b done=%b, want phase=%h level=%h running=%b done=%b",
                         q[0].name, stage_phase, stage_level, running, cycle_done,
                         q[0].ph, q[0].lv, q[0].run, q[0].cd);
            end
            void'(q.pop_front());
        end
    end

    task automatic push(input int c, input logic [7:0] ph, input logic [15:0] lv,
                        input logic r, input logic cd, input string nm);
        exp_t e;
        e.at = t0 + c - 1;
        e.ph = ph;
        e.lv = lv;
        e.run = r;
        e.cd = cd;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic drain_q();
        for (int i = 0; i < 400 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d expectations left unchecked, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < t0 + c - 1) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if (stage_phase !== 8'h00 || stage_level !== 16'h0000 ||
            running !== 1'b0 || cycle_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got phase=%h level=%h running=%b done=%b, want all zero",
                     nm, stage_phase, stage_level, running, cycle_done);
        end
    endtask

    task automatic start_run(input logic [3:0] rl, input logic stp);
        @(negedge clk);
        start = 1'b1;
        stop = stp;
        ramp_len = rl;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        t0 = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        ramp_len = 4'd0;
        #3;
        chk_zero("reset_state");

        // ramp_len=3, start accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        ramp_len = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        push(1,  8'h01, 16'h0000, 1'b1, 1'b0, "a_c1_eval0");
        push(4,  8'h01, 16'h0003, 1'b1, 1'b0, "a_c4_eval3");
        push(5,  8'h06, 16'h0003, 1'b1, 1'b0, "a_c5_hold_s1eval");
        push(6,  8'h06, 16'h0013, 1'b1, 1'b0, "a_c6");
        push(13, 8'h6C, 16'h0330, 1'b1, 1'b0, "a_c13_s3eval");
        push(15, 8'h6C, 16'h2310, 1'b1, 1'b0, "a_c15");
        push(24, 8'hC6, 16'h0033, 1'b1, 1'b0, "a_c24");
        push(25, 8'h1B, 16'h0033, 1'b1, 1'b1, "a_c25_done");
        push(26, 8'h1B, 16'h0132, 1'b1, 1'b0, "a_c26");
        push(41, 8'h1B, 16'h0033, 1'b1, 1'b1, "a_c41_done");
        push(45, 8'h6C, 16'h0330, 1'b1, 1'b0, "a_c45_drain");
        push(49, 8'hB0, 16'h3300, 1'b1, 1'b0, "a_c49_drain");
        push(53, 8'hC0, 16'h3000, 1'b1, 1'b0, "a_c53_drain");
        push(57, 8'h00, 16'h0000, 1'b0, 1'b1, "a_c57_final_done");
        push(58, 8'h00, 16'h0000, 1'b0, 1'b0, "a_c58_idle");
        at_cycle(30);
        ramp_len = 4'd9;
        at_cycle(42);
        stop = 1'b1;
        at_cycle(44);
        stop = 1'b0;
        at_cycle(50);
        start = 1'b1;
        at_cycle(51);
        start = 1'b0;
        drain_q();

        // ramp_len=0: one-cycle phases, levels stay zero
        start_run(4'd0, 1'b0);
        push(1, 8'h01, 16'h0000, 1'b1, 1'b0, "b_c1");
        push(2, 8'h06, 16'h0000, 1'b1, 1'b0, "b_c2");
        push(3, 8'h1B, 16'h0000, 1'b1, 1'b0, "b_c3");
        push(4, 8'h6C, 16'h0000, 1'b1, 1'b0, "b_c4");
        push(5, 8'hB1, 16'h0000, 1'b1, 1'b0, "b_c5");
        push(6, 8'hC6, 16'h0000, 1'b1, 1'b0, "b_c6");
        push(7, 8'h1B, 16'h0000, 1'b1, 1'b1, "b_c7_done");
        drain_q();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("b_async_reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;

        // ramp_len=7, reset mid-HOLD, restart straight out of reset
        start_run(4'd7, 1'b0);
        push(10, 8'h06, 16'h0017, 1'b1, 1'b0, "c_c10_hold");
        drain_q();
        at_cycle(12);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("c_async_reset_mid_hold");
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        ramp_len = 4'd7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        push(1, 8'h01, 16'h0000, 1'b1, 1'b0, "c_restart_c1");
        push(2, 8'h01, 16'h0001, 1'b1, 1'b0, "c_restart_c2");
        drain_q();
        do_reset();

        // start and stop together in IDLE: start wins, no drain
        start_run(4'd1, 1'b1);
        push(7,  8'h6C, 16'h0110, 1'b1, 1'b0, "d_c7_no_drain");
        push(13, 8'h1B, 16'h0011, 1'b1, 1'b1, "d_c13_done");
        drain_q();
        do_reset();

        // stop before stage 3 is enabled: only stages 1,2 drain, no done pulse
        @(negedge clk);
        start = 1'b1;
        ramp_len = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b1;
        t0 = cyc;
        push(7,  8'h2C, 16'h0110, 1'b1, 1'b0, "e_c7_drain");
        push(9,  8'h30, 16'h0100, 1'b1, 1'b0, "e_c9_drain");
        push(11, 8'h00, 16'h0000, 1'b0, 1'b0, "e_c11_idle");
        @(posedge clk);
        #1;
        stop = 1'b0;
        drain_q();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
